dual_ant_power_detect: RTL

Per-antenna power estimator and power trigger for the two-antenna receive front end. It takes both antennas' IQ streams and produces, for each antenna, a smoothed RSSI in half-dB units and a hysteresis-qualified power trigger. It sits directly upstream of the antenna-switch/short-preamble stage, which consumes `rssi1_half_db_1`, `rssi2_half_db_2`, `power_trigger_1` and `power_trigger_2`.

---
 rtl/dual_ant_power_detect_pkg.sv | 31 +++
 rtl/dual_ant_power_detect_if.sv | 32 +++
 rtl/dual_ant_power_detect_rssi_chain.sv | 109 ++++++++++
 rtl/dual_ant_power_detect.sv | 48 ++++
 4 files changed

// File: rtl/dual_ant_power_detect_pkg.sv
// dual_ant_power_detect_pkg: shared trigger states, log-conversion constants and RSSI width
//   RSSI_W            : width of every RSSI value (half-dB units)
//   LOG_* constants   : 12 half-dB per octave, 3/2 half-dB per mantissa step
//   trig_state_t      : power-trigger FSM encoding
//   log_half_db()     : integer average -> RSSI in half-dB
package dual_ant_power_detect_pkg;
    localparam int RSSI_W = 11;
    localparam int LOG_OCTAVE_HALF_DB = 12;
    localparam int LOG_MANT_MUL = 3;
    localparam int LOG_MANT_SHIFT = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } trig_state_t;

    // Piecewise-linear log2: the leading-one position gives the octave and the
    // three bits just below it interpolate within the octave.
    function automatic logic [RSSI_W-1:0] log_half_db(input logic [31:0] avg);
        int p;
        logic [34:0] ext;
        logic [2:0] f;
        p = 0;
        for (int k = 0; k < 32; k++)
            if (avg[k]) p = k;
        ext = {avg, 3'b000};
        f = ext[p +: 3];
        return (avg == 32'd0) ? '0
             : RSSI_W'(LOG_OCTAVE_HALF_DB * p + ((LOG_MANT_MUL * int'(f)) >> LOG_MANT_SHIFT));
    endfunction
endpackage

// File: rtl/dual_ant_power_detect_if.sv
// dual_ant_power_detect_if: sample/control/result bundle of the dual-antenna power detector
//   enable, data_in_strobe, data_ant1_in, data_ant2_in : sample side
//   power_thres, min_power_hold                        : live trigger configuration
//   rssi1_half_db_1, rssi2_half_db_2, rssi_strobe      : RSSI results
//   power_trigger_1, power_trigger_2                   : per-antenna triggers
interface dual_ant_power_detect_if
    import dual_ant_power_detect_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 16
);
    logic                       enable;
    logic                       data_in_strobe;
    logic [2*IQ_DATA_WIDTH-1:0] data_ant1_in;
    logic [2*IQ_DATA_WIDTH-1:0] data_ant2_in;
    logic [RSSI_W-1:0]          power_thres;
    logic [15:0]                min_power_hold;
    logic [RSSI_W-1:0]          rssi1_half_db_1;
    logic [RSSI_W-1:0]          rssi2_half_db_2;
    logic                       rssi_strobe;
    logic                       power_trigger_1;
    logic                       power_trigger_2;

    modport master (
        output enable, data_in_strobe, data_ant1_in, data_ant2_in, power_thres, min_power_hold,
        input  rssi1_half_db_1, rssi2_half_db_2, rssi_strobe, power_trigger_1, power_trigger_2
    );

    modport slave (
        input  enable, data_in_strobe, data_ant1_in, data_ant2_in, power_thres, min_power_hold,
        output rssi1_half_db_1, rssi2_half_db_2, rssi_strobe, power_trigger_1, power_trigger_2
    );
endinterface

// File: rtl/dual_ant_power_detect_rssi_chain.sv
// rssi_chain: one antenna's magnitude, moving average, log RSSI and hysteresis power trigger
//   clock, reset        : system clock, synchronous active-high reset
//   enable              : when low, strobes are dropped and every register holds
//   data_in_strobe      : qualifies data_in, packed {I, Q}
//   power_thres         : trigger threshold in half-dB
//   min_power_hold      : consecutive below-threshold updates needed to drop the trigger
//   rssi, rssi_valid    : RSSI in half-dB and its one-cycle update pulse
//   power_trigger       : hysteresis-qualified trigger
module rssi_chain
    import dual_ant_power_detect_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int WINDOW_LOG2   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       data_in_strobe,
    input  logic [2*IQ_DATA_WIDTH-1:0] data_in,
    input  logic [RSSI_W-1:0]          power_thres,
    input  logic [15:0]                min_power_hold,
    output logic [RSSI_W-1:0]          rssi,
    output logic                       rssi_valid,
    output logic                       power_trigger
);
    localparam int MAG_W = IQ_DATA_WIDTH + 1;
    localparam int SUM_W = MAG_W + WINDOW_LOG2;
    localparam int DEPTH = 1 << WINDOW_LOG2;

    logic signed [MAG_W-1:0] i_ext, q_ext;
    logic [MAG_W-1:0] i_abs, q_abs, mag, mag_s1, avg;
    logic [MAG_W-1:0] delay_line [DEPTH];
    logic [SUM_W-1:0] sum;
    logic v1, v2, v3, hit;
    trig_state_t state, state_n;
    logic [15:0] cnt, cnt_n, cnt_inc;

    // One extra bit makes |-2^(W-1)| exact, so no saturation is needed.
    assign i_ext = {data_in[2*IQ_DATA_WIDTH-1], data_in[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH]};
    assign q_ext = {data_in[IQ_DATA_WIDTH-1], data_in[IQ_DATA_WIDTH-1:0]};
    assign i_abs = i_ext[MAG_W-1] ? -i_ext : i_ext;
    assign q_abs = q_ext[MAG_W-1] ? -q_ext : q_ext;
    assign mag   = i_abs + q_abs;

    assign avg     = sum[SUM_W-1:WINDOW_LOG2];
    assign hit     = rssi >= power_thres;
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            mag_s1 <= '0;
            sum    <= '0;
            rssi   <= '0;
            state  <= IDLE;
            cnt    <= '0;
            for (int k = 0; k < DEPTH; k++) delay_line[k] <= '0;
        end else if (enable) begin
            v1 <= data_in_strobe;
            v2 <= v1;
            v3 <= v2;
            if (data_in_strobe) mag_s1 <= mag;
            // Slots not yet filled since reset hold 0, so the running sum is exact from the first sample.
            if (v1) begin
                sum           <= sum + SUM_W'(mag_s1) - SUM_W'(delay_line[DEPTH-1]);
                delay_line[0] <= mag_s1;
                for (int k = 1; k < DEPTH; k++) delay_line[k] <= delay_line[k-1];
            end
            if (v2) rssi <= log_half_db(32'(avg));
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (v3) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state_n = ACTIVE;
                        cnt_n   = '0;
                    end
                end
                ACTIVE: begin
                    if (hit) begin
                        cnt_n = '0;
                    end else if (cnt_inc >= min_power_hold) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // A valid parked in stage 3 while disabled must not be reported until enable returns.
    assign rssi_valid    = v3 & enable;
    assign power_trigger = state == ACTIVE;
endmodule

// File: rtl/dual_ant_power_detect.sv
// dual_ant_power_detect: per-antenna smoothed RSSI (half-dB) and hysteresis power trigger for two antennas
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : samples, strobe, enable, live thresholds in; RSSI, rssi_strobe, triggers out
module dual_ant_power_detect
    import dual_ant_power_detect_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int WINDOW_LOG2   = 4
) (
    input logic                     clock,
    input logic                     reset,
    dual_ant_power_detect_if.slave  bus
);
    // Both chains advance in lockstep, so chain 2's valid duplicates chain 1's.
    logic valid2_unused;

    rssi_chain #(
        .IQ_DATA_WIDTH(IQ_DATA_WIDTH),
        .WINDOW_LOG2  (WINDOW_LOG2)
    ) u_chain1 (
        .clock         (clock),
        .reset         (reset),
        .enable        (bus.enable),
        .data_in_strobe(bus.data_in_strobe),
        .data_in       (bus.data_ant1_in),
        .power_thres   (bus.power_thres),
        .min_power_hold(bus.min_power_hold),
        .rssi          (bus.rssi1_half_db_1),
        .rssi_valid    (bus.rssi_strobe),
        .power_trigger (bus.power_trigger_1)
    );

    rssi_chain #(
        .IQ_DATA_WIDTH(IQ_DATA_WIDTH),
        .WINDOW_LOG2  (WINDOW_LOG2)
    ) u_chain2 (
        .clock         (clock),
        .reset         (reset),
        .enable        (bus.enable),
        .data_in_strobe(bus.data_in_strobe),
        .data_in       (bus.data_ant2_in),
        .power_thres   (bus.power_thres),
        .min_power_hold(bus.min_power_hold),
        .rssi          (bus.rssi2_half_db_2),
        .rssi_valid    (valid2_unused),
        .power_trigger (bus.power_trigger_2)
    );
endmodule
